// File: rtl/sram_bridge.sv
// sram_bridge: bridges the cache's single-word memory request interface to an
// external asynchronous 16-bit SRAM. Each 32-bit access is split into two
// half-word cycles, low half first. Every SRAM strobe lasts WAITSTATES+1 cycles.
//
// Optional feature (macro SRAM_READBUF_EN): a one-entry read buffer. A read
// that hits the buffered word is answered one cycle after acceptance, with no
// SRAM cycle.
//
// Ports:
//   clk, reset             system clock; synchronous active-high reset
//   mem_addr               byte address from the cache (bits [1:0] ignored)
//   mem_in                 write data
//   mem_rdreq, mem_wrreq   read / write request, sampled only while mem_ready
//   mem_out                read data (holds its value between reads)
//   mem_out_valid          one-cycle pulse marking new mem_out data
//   mem_ready              high only in IDLE
//   sram_addr              half-word address to the SRAM
//   sram_dq_out/_in/_oe    data pad out / in / output enable
//   sram_ce_n/oe_n/we_n    active-low SRAM strobes (all registered)
module sram_bridge #(
  parameter int ADDRBITS     = 32,
  parameter int DATABITS     = 32,
  parameter int SRAMADDRBITS = 18,
  parameter int WAITSTATES   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRBITS-1:0]     mem_addr,
  input  logic [DATABITS-1:0]     mem_in,
  input  logic                    mem_rdreq,
  input  logic                    mem_wrreq,
  output logic [DATABITS-1:0]     mem_out,
  output logic                    mem_out_valid,
  output logic                    mem_ready,
  output logic [SRAMADDRBITS-1:0] sram_addr,
  output logic [15:0]             sram_dq_out,
  input  logic [15:0]             sram_dq_in,
  output logic                    sram_dq_oe,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n
);

  localparam int HALF     = DATABITS / 2;
  localparam int WORDBITS = ADDRBITS - 2;
  localparam int SW       = SRAMADDRBITS - 1;  // word-index bits that reach the SRAM
  localparam int CNTW     = (WAITSTATES > 0) ? $clog2(WAITSTATES + 1) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WAITSTATES);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

  state_t                    state_q, state_d;
  logic                      half_q, half_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic [WORDBITS-1:0]       word_q, word_d;
  logic [DATABITS-1:0]       wdata_q, wdata_d;
  logic [DATABITS-1:0]       mem_out_d;
  logic                      mem_out_valid_d;
  logic [SRAMADDRBITS-1:0]   addr_d;
  logic [15:0]               dq_out_d;
  logic                      dq_oe_d, ce_n_d, oe_n_d, we_n_d;

  logic [WORDBITS-1:0]       req_word;
  logic                      strobe_last;
  logic                      buf_hit;
  logic [DATABITS-1:0]       buf_rdata;

  assign req_word    = mem_addr[ADDRBITS-1:2];
  assign strobe_last = (cnt_q == CNT_LAST);
  assign mem_ready   = (state_q == IDLE);

  // Byte-offset bits and word-index bits above the SRAM's reach are unused.
  logic unused_bits;
  assign unused_bits = ^{mem_addr[1:0], word_q[WORDBITS-1:SW]};

`ifdef SRAM_READBUF_EN
  logic                buf_valid_q;
  logic [WORDBITS-1:0] buf_word_q;
  logic [DATABITS-1:0] buf_data_q;

  assign buf_hit   = buf_valid_q && (buf_word_q == req_word);
  assign buf_rdata = buf_data_q;

  // NOTE: only the valid bit needs a reset; tag and data are meaningless
  // until valid is set, so they are left as plain data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
    end else if (state_q == IDLE && mem_wrreq && buf_hit) begin
      buf_valid_q <= 1'b0;
    end else if (state_q == RD && strobe_last && half_q) begin
      buf_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == RD && strobe_last && half_q) begin
      buf_word_q <= word_q;
      buf_data_q <= {sram_dq_in, mem_out[HALF-1:0]};
    end
  end
`else
  assign buf_hit   = 1'b0;
  assign buf_rdata = '0;
`endif

  // NOTE: every variable gets its hold/default value first so that no path
  // through the case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d         = state_q;
    half_d          = half_q;
    cnt_d           = cnt_q;
    word_d          = word_q;
    wdata_d         = wdata_q;
    mem_out_d       = mem_out;
    mem_out_valid_d = 1'b0;
    addr_d          = sram_addr;
    dq_out_d        = sram_dq_out;
    dq_oe_d         = sram_dq_oe;
    ce_n_d          = sram_ce_n;
    oe_n_d          = sram_oe_n;
    we_n_d          = sram_we_n;

    case (state_q)
      IDLE: begin
        // A write wins over a simultaneous read; the read is dropped.
        if (mem_wrreq) begin
          state_d  = WR_SETUP;
          half_d   = 1'b0;
          cnt_d    = '0;
          word_d   = req_word;
          wdata_d  = mem_in;
          addr_d   = {req_word[SW-1:0], 1'b0};
          dq_out_d = mem_in[HALF-1:0];
          dq_oe_d  = 1'b1;
          ce_n_d   = 1'b0;
          we_n_d   = 1'b1;
        end else if (mem_rdreq && buf_hit) begin
          state_d         = DONE;
          mem_out_d       = buf_rdata;
          mem_out_valid_d = 1'b1;
        end else if (mem_rdreq) begin
          state_d = RD;
          half_d  = 1'b0;
          cnt_d   = '0;
          word_d  = req_word;
          addr_d  = {req_word[SW-1:0], 1'b0};
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b0;
        end
      end

      RD: begin
        if (strobe_last) begin
          cnt_d = '0;
          if (half_q) mem_out_d[DATABITS-1:HALF] = sram_dq_in;
          else        mem_out_d[HALF-1:0]        = sram_dq_in;
          if (!half_q) begin
            half_d = 1'b1;
            addr_d = {word_q[SW-1:0], 1'b1};
          end else begin
            state_d         = DONE;
            ce_n_d          = 1'b1;
            oe_n_d          = 1'b1;
            mem_out_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = '0;
        we_n_d  = 1'b0;
      end

      WR_PULSE: begin
        if (strobe_last) begin
          state_d = WR_HOLD;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WR_HOLD: begin
        if (!half_q) begin
          state_d  = WR_SETUP;
          half_d   = 1'b1;
          addr_d   = {word_q[SW-1:0], 1'b1};
          dq_out_d = wdata_q[DATABITS-1:HALF];
        end else begin
          state_d = DONE;
          ce_n_d  = 1'b1;
          dq_oe_d = 1'b0;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      half_q        <= 1'b0;
      cnt_q         <= '0;
      word_q        <= '0;
      wdata_q       <= '0;
      mem_out       <= '0;
      mem_out_valid <= 1'b0;
      sram_addr     <= '0;
      sram_dq_out   <= '0;
      sram_dq_oe    <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
    end else begin
      state_q       <= state_d;
      half_q        <= half_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      wdata_q       <= wdata_d;
      mem_out       <= mem_out_d;
      mem_out_valid <= mem_out_valid_d;
      sram_addr     <= addr_d;
      sram_dq_out   <= dq_out_d;
      sram_dq_oe    <= dq_oe_d;
      sram_ce_n     <= ce_n_d;
      sram_oe_n     <= oe_n_d;
      sram_we_n     <= we_n_d;
    end
  end

endmodule

// File: tb/tb_sram_bridge.sv
// Testbench for sram_bridge. Two instances: dut (WAITSTATES=1) carries most of
// the stimulus; dut0 (WAITSTATES=0) checks the zero-wait read timing. A shared
// half-word SRAM model answers reads from both and takes writes from dut.
// Cycle numbering: the request-acceptance edge is E0; "cycle k" is the
// interval after E(k-1), sampled at its falling edge.
module tb_sram_bridge;

  localparam int WS       = 1;
  localparam int RD_VALID = 2 * (WS + 1) + 1;  // valid cycle of an SRAM read
  localparam int WR_READY = 2 * (WS + 3) + 2;  // mem_ready cycle after a write
`ifdef SRAM_READBUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr, mem_in, mem_out;
  logic        mem_rdreq, mem_wrreq, mem_out_valid, mem_ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in = 16'h0;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  logic [31:0] mem_addr0, mem_out0;
  logic [31:0] mem_in0 = 32'h0;
  logic        mem_wrreq0 = 1'b0;
  logic        mem_rdreq0, mem_out_valid0, mem_ready0;
  logic [17:0] sram_addr0;
  logic [15:0] sram_dq_out0;
  logic [15:0] sram_dq_in0 = 16'h0;
  logic        sram_dq_oe0, sram_ce_n0, sram_oe_n0, sram_we_n0;

  always #5 clk = ~clk;

  sram_bridge #(.WAITSTATES(WS)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq), .mem_out(mem_out),
    .mem_out_valid(mem_out_valid), .mem_ready(mem_ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  sram_bridge #(.WAITSTATES(0)) dut0 (
    .clk(clk), .reset(reset), .mem_addr(mem_addr0), .mem_in(mem_in0),
    .mem_rdreq(mem_rdreq0), .mem_wrreq(mem_wrreq0), .mem_out(mem_out0),
    .mem_out_valid(mem_out_valid0), .mem_ready(mem_ready0), .sram_addr(sram_addr0),
    .sram_dq_out(sram_dq_out0), .sram_dq_in(sram_dq_in0), .sram_dq_oe(sram_dq_oe0),
    .sram_ce_n(sram_ce_n0), .sram_oe_n(sram_oe_n0), .sram_we_n(sram_we_n0)
  );

  // ---------------- SRAM model ----------------
  logic [15:0] sram [int];

  function automatic logic [15:0] sram_rd(input logic [17:0] a);
    if (sram.exists(int'({14'b0, a}))) return sram[int'({14'b0, a})];
    return 16'h0;
  endfunction

  always @(negedge clk) begin
    sram_dq_in  = (!sram_ce_n  && !sram_oe_n)  ? sram_rd(sram_addr)  : 16'h0;
    sram_dq_in0 = (!sram_ce_n0 && !sram_oe_n0) ? sram_rd(sram_addr0) : 16'h0;
  end

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe)
      sram[int'({14'b0, sram_addr})] = sram_dq_out;
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;
  int viol     = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Strobe-overlap and pad-contention rules, watched on every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (!sram_oe_n && !sram_we_n) viol++;
      if (sram_dq_oe && !sram_oe_n) viol++;
      if ((!sram_oe_n || !sram_we_n) && sram_ce_n) viol++;
      if (!sram_oe_n0 && !sram_we_n0) viol++;
      if (sram_dq_oe0 && !sram_oe_n0) viol++;
      if ((!sram_oe_n0 || !sram_we_n0) && sram_ce_n0) viol++;
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_ce_n"},  sram_ce_n, 1);
    check({tag, "_oe_n"},  sram_oe_n, 1);
    check({tag, "_we_n"},  sram_we_n, 1);
    check({tag, "_dq_oe"}, sram_dq_oe, 0);
    check({tag, "_ready"}, mem_ready, 1);
    check({tag, "_valid"}, mem_out_valid, 0);
  endtask

  // Per-transaction observations.
  int          r_valid_cnt, r_valid_cyc, r_ready_cyc;
  logic [31:0] r_data;
  logic [63:0] r_oe_mask, r_we_mask;
  logic [17:0] r_oe_addr [64];

  // Presents one request for one edge, then watches until mem_ready returns.
  // With noise set, a conflicting read+write is held while mem_ready is low.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic noise);
    int guard = 0;
    @(negedge clk);
    while (!mem_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    mem_rdreq = rd; mem_wrreq = wr; mem_addr = a; mem_in = d;
    @(posedge clk);
    #1;
    mem_rdreq = 1'b0; mem_wrreq = 1'b0; mem_addr = 32'hFFFF_FFF0; mem_in = ~d;
    r_valid_cnt = 0; r_valid_cyc = -1; r_ready_cyc = -1; r_data = 32'h0;
    r_oe_mask = '0; r_we_mask = '0;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      if (!sram_oe_n) begin r_oe_mask[c] = 1'b1; r_oe_addr[c] = sram_addr; end
      if (!sram_we_n) r_we_mask[c] = 1'b1;
      if (mem_out_valid) begin r_valid_cnt++; r_valid_cyc = c; r_data = mem_out; end
      if (mem_ready) begin r_ready_cyc = c; break; end
      if (noise) begin
        mem_rdreq = 1'b1; mem_wrreq = 1'b1; mem_addr = 32'h3F0; mem_in = 32'hBAD0BAD0;
      end
    end
    mem_rdreq = 1'b0; mem_wrreq = 1'b0;
    if (r_ready_cyc < 0) check("txn_timeout", 1, 0);
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic        noise;
    int          exp_valid_cnt;
    logic [31:0] exp_data;
    int          exp_valid_cyc;
    int          exp_ready;
    logic [63:0] exp_oe_mask, exp_we_mask;
  } vec_t;

  vec_t        tbl [6];
  logic [31:0] model_mem [8];
  logic [31:0] last_rd;
  logic [63:0] mask0;
  logic [31:0] data0, d, a;
  int          vc0, rc0, op, idx, exp_cyc;
  logic        rd, wr, bv, hit;
  int          bidx;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sram[32'h10] = 16'hBEEF;
    sram[32'h11] = 16'hDEAD;
    reset = 1'b1; mem_rdreq = 1'b0; mem_wrreq = 1'b0; mem_addr = '0; mem_in = '0;
    mem_rdreq0 = 1'b0; mem_addr0 = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset_init");
    check("reset_mem_out", mem_out, 0);
    check("reset_sram_addr", sram_addr, 0);
    check("reset_dq_out", sram_dq_out, 0);
    reset = 1'b0;

    // ---- reset in the middle of a read ----
    @(negedge clk);
    mem_rdreq = 1'b1; mem_addr = 32'h20;
    @(posedge clk);
    #1 mem_rdreq = 1'b0;
    @(negedge clk);
    check("abort_read_started", sram_oe_n, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset_mid_read");
    check("reset_mid_read_mem_out", mem_out, 0);
    @(negedge clk);
    check_idle("after_reset");

    // ---- directed read of 0x20 ----
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("rd20_data", r_data, 32'hDEADBEEF);
    check("rd20_valid_cnt", r_valid_cnt, 1);
    check("rd20_valid_cyc", r_valid_cyc, 5);
    check("rd20_ready", r_ready_cyc, 6);
    check("rd20_oe_mask", r_oe_mask, 64'h1E);
    check("rd20_addr_c1", r_oe_addr[1], 18'h10);
    check("rd20_addr_c2", r_oe_addr[2], 18'h10);
    check("rd20_addr_c3", r_oe_addr[3], 18'h11);
    check("rd20_addr_c4", r_oe_addr[4], 18'h11);

    // ---- zero-wait-state instance: read of 0x20 ----
    @(negedge clk);
    mem_rdreq0 = 1'b1; mem_addr0 = 32'h20;
    @(posedge clk);
    #1 mem_rdreq0 = 1'b0;
    mask0 = '0; vc0 = -1; rc0 = -1; data0 = '0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (!sram_oe_n0) mask0[c] = 1'b1;
      if (mem_out_valid0) begin vc0 = c; data0 = mem_out0; end
      if (mem_ready0) begin rc0 = c; break; end
    end
    check("ws0_oe_mask", mask0, 64'h6);
    check("ws0_valid_cyc", vc0, 3);
    check("ws0_data", data0, 32'hDEADBEEF);
    check("ws0_ready", rc0, 4);

    // ---- table-driven transactions (WAITSTATES=1) ----
    //            rd    wr    addr         wdata         noise vcnt data          vcyc rdy oe     we
    tbl[0] = '{1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0, 0, 32'h0,        -1, 10, 64'h0,  64'hCC};
    tbl[1] = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b0, 1, 32'h12345678,  5,  6, 64'h1E, 64'h0};
    tbl[2] = '{1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 1'b1, 0, 32'h0,        -1, 10, 64'h0,  64'hCC};
    tbl[3] = '{1'b1, 1'b0, 32'h80, 32'h0,        1'b1, 1, 32'hCAFEF00D,  5,  6, 64'h1E, 64'h0};
    tbl[4] = '{1'b0, 1'b1, 32'h44, 32'hA5A50F0F, 1'b0, 0, 32'h0,        -1, 10, 64'h0,  64'hCC};
    tbl[5] = '{1'b1, 1'b0, 32'h47, 32'h0,        1'b0, 1, 32'hA5A50F0F,  5,  6, 64'h1E, 64'h0};
    last_rd = 32'hDEADBEEF;
    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].noise);
      check($sformatf("tbl%0d_valid_cnt", i), r_valid_cnt, tbl[i].exp_valid_cnt);
      check($sformatf("tbl%0d_valid_cyc", i), r_valid_cyc, tbl[i].exp_valid_cyc);
      check($sformatf("tbl%0d_ready", i), r_ready_cyc, tbl[i].exp_ready);
      check($sformatf("tbl%0d_oe_mask", i), r_oe_mask, tbl[i].exp_oe_mask);
      check($sformatf("tbl%0d_we_mask", i), r_we_mask, tbl[i].exp_we_mask);
      if (tbl[i].exp_valid_cnt != 0) begin
        check($sformatf("tbl%0d_data", i), r_data, tbl[i].exp_data);
        last_rd = tbl[i].exp_data;
      end else begin
        check($sformatf("tbl%0d_mem_out_hold", i), mem_out, last_rd);
      end
    end
    check("wr40_low_half", sram_rd(18'h20), 16'h5678);
    check("wr40_high_half", sram_rd(18'h21), 16'h1234);
    check("wr80_low_half", sram_rd(18'h40), 16'hF00D);
    check("wr80_high_half", sram_rd(18'h41), 16'hCAFE);
    check("busy_requests_ignored",
          {sram.exists(32'h1F8), sram.exists(32'h1F9)}, 2'b00);

    // ---- read buffer sequence (SRAM read every time when disabled) ----
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("buf_first_data", r_data, 32'hDEADBEEF);
    check("buf_first_valid_cyc", r_valid_cyc, RD_VALID);
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("buf_second_data", r_data, 32'hDEADBEEF);
    check("buf_second_valid_cyc", r_valid_cyc, BUF_EN ? 1 : RD_VALID);
    check("buf_second_oe_mask", r_oe_mask, BUF_EN ? 64'h0 : 64'h1E);
    check("buf_second_ready", r_ready_cyc, BUF_EN ? 2 : RD_VALID + 1);
    run_txn(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 1'b0);
    check("buf_write_ready", r_ready_cyc, WR_READY);
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("buf_after_write_data", r_data, 32'h0BADF00D);
    check("buf_after_write_valid_cyc", r_valid_cyc, RD_VALID);
    check("buf_after_write_oe_mask", r_oe_mask, 64'h1E);
    last_rd = 32'h0BADF00D;

    // ---- randomized traffic against a word-level reference model ----
    // The model's buffer starts empty; the word still held by the DUT's
    // buffer (index 8) lies outside the random address window.
    bv = 1'b0; bidx = 0;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      run_txn(1'b0, 1'b1, 32'h100 + 32'(4 * i), d, 1'b0);
      model_mem[i] = d;
      check("rnd_fill_ready", r_ready_cyc, WR_READY);
    end
    for (int n = 0; n < 50; n++) begin
      op  = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, 7));
      a   = 32'h100 + 32'(4 * idx) + 32'($urandom_range(0, 3));
      d   = $urandom;
      rd  = (op != 2);
      wr  = (op >= 2);
      run_txn(rd, wr, a, d, 1'($urandom_range(0, 1)));
      if (wr) begin
        model_mem[idx] = d;
        if (bv && bidx == idx) bv = 1'b0;
        check("rnd_wr_ready", r_ready_cyc, WR_READY);
        check("rnd_wr_no_valid", r_valid_cnt, 0);
        check("rnd_wr_mem_out_hold", mem_out, last_rd);
      end else begin
        hit     = BUF_EN && bv && (bidx == idx);
        exp_cyc = hit ? 1 : RD_VALID;
        check("rnd_rd_data", r_data, model_mem[idx]);
        check("rnd_rd_valid_cnt", r_valid_cnt, 1);
        check("rnd_rd_valid_cyc", r_valid_cyc, exp_cyc);
        check("rnd_rd_ready", r_ready_cyc, exp_cyc + 1);
        last_rd = model_mem[idx];
        bv = 1'b1; bidx = idx;
      end
    end

    check("protocol_violations", viol, 0);
    check("dut0_dq_out_idle", sram_dq_out0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
